fft256_ctrl: RTL and testbench
==============================

Name: fft256_ctrl

Overview:
- Sequencer for the 256-point radix-2 in-place FFT datapath: working buffer, butterfly pipeline and twiddle ROM.
- Accepts one frame of streaming samples and generates bit-reversed write addresses for the buffer.
- Schedules 8 stages x 128 butterflies with a hazard drain between stages, then reads the result out in natural order with valid_out/sop_out framing.
- Generates addresses and strobes only; it carries no sample data.

Parameters:
- N, 256, points per frame
- LOGN, 8, stage count and address width
- BF_LAT, 4, butterfly read-to-writeback latency in cycles
- RD_LAT, 1, buffer read latency in cycles

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- inv  in  1  inverse-FFT request, sampled with the accepted sop_in
- valid_in  in  1  input sample strobe
- sop_in  in  1  first sample of frame, qualified by valid_in
- wr_en  out  1  buffer write strobe, load phase
- wr_addr  out  8  bit-reversed load address
- bf_en  out  1  butterfly issue strobe
- bf_addr_a  out  8  butterfly upper operand address
- bf_addr_b  out  8  butterfly lower operand address (a + 2^stage)
- tw_idx  out  7  twiddle ROM index
- stage  out  3  current stage 0..7
- wb_en  out  1  bf_en delayed BF_LAT cycles
- wb_addr_a  out  8  bf_addr_a delayed BF_LAT cycles
- wb_addr_b  out  8  bf_addr_b delayed BF_LAT cycles
- inv_q  out  1  latched inv, held for the whole frame
- rd_en  out  1  output read strobe
- rd_addr  out  8  natural-order read address
- valid_out  out  1  rd_en delayed RD_LAT cycles
- sop_out  out  1  first output sample, aligned to valid_out
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on a dropped or aborted input

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- IDLE:
  - valid_in & sop_in: write sample 0 at wr_addr 0, set cnt = 1, latch inv, go to LOAD.
  - valid_in without sop_in: ignored, no err.
- LOAD:
  - Each valid_in: wr_en = 1, wr_addr = bitrev8(cnt), cnt++. Gaps in valid_in hold cnt.
  - valid_in & sop_in mid-frame: err pulse; restart the frame with this sample as sample 0; re-latch inv.
  - When sample 255 is written, go to CALC on the next cycle.
- CALC (s = stage, k = butterfly counter 0..127):
  - bf_en = 1 every cycle.
  - pos = k mod 2^s; grp = k >> s.
  - bf_addr_a = grp * 2^(s+1) + pos; bf_addr_b = bf_addr_a + 2^s.
  - tw_idx = pos << (7 - s). The twiddle conjugate for inverse is applied in the datapath from inv_q.
  - At k = 127, go to DRAIN.
- DRAIN:
  - bf_en = 0 for BF_LAT cycles so stage s writebacks land before stage s+1 reads.
  - Then: if s < 7, s++ and k = 0, back to CALC; else go to UNLOAD.
- wb_en and wb_addr_a/b: shift-register delay of bf_en and the bf addresses. They remain valid through DRAIN.
- UNLOAD:
  - rd_en = 1 for 256 cycles, rd_addr = 0..255.
  - valid_out and sop_out are rd_en and (rd_addr == 0) delayed RD_LAT.
  - After the last rd_en, return to IDLE. The final valid_out completes RD_LAT cycles later.
  - A sop_in during those RD_LAT cycles is accepted.
- Input during CALC, DRAIN or UNLOAD: dropped; err pulses once per valid_in cycle.
- Latency, last input write at cycle T:
  - First bf_en at T+1.
  - Compute plus drain: 8 * (128 + BF_LAT) = 1056 cycles.
  - First rd_en at T+1057; first valid_out at T+1057+RD_LAT.
  - Total with defaults: valid_out/sop_out at T+1058; last valid_out at T+1313.
- rst asserted mid-frame: immediate return to IDLE and all strobes 0 next cycle. Partial frame discarded, no err.

Decomposition:
- Package fft256_pkg:
  - Constants: N, LOGN, BF_LAT, RD_LAT.
  - State enum: IDLE, LOAD, CALC, DRAIN, UNLOAD.
  - bitrev8 function.
- Sub-module fft256_agu: combinational butterfly/twiddle address generator, inputs (s, k), outputs (a, b, tw_idx).
- Delay lines stay inline in fft256_ctrl.

Test Plan:
- Contiguous frame (sop at sample 0, 256 valid) -> wr_addr sequence 0, 128, 64, 192, ...; first bf_en 1 cycle after the last write; sop_out at T+1058; exactly 256 valid_out, rd_addr 0..255.
- Stage address check: stage 0 k = 0,1 -> (a,b) = (0,1),(2,3) with tw 0; stage 3 k = 9 -> a = 17, b = 25, tw = 16; stage 7 k = 127 -> a = 127, b = 255, tw = 127.
- Gapped input (valid_in 1-of-3 cycles) -> cnt holds in gaps; CALC entered only after the 256th write; addresses identical to the contiguous case.
- sop_in at sample 100 -> err pulse; wr_addr returns to 0; frame completes 256 samples after the new sop.
- valid_in during CALC and during UNLOAD -> err pulses once per such cycle; no wr_en; outputs unaffected.
- rst at stage 4 k = 50 -> next cycle all strobes 0 and busy = 0; a fresh frame afterwards runs to completion normally with the inv value latched at its sop.

Source files
------------

// File: rtl/fft256_pkg.sv
// Shared constants, sequencer states and the load-address helper for the
// 256-point in-place FFT control slice.
package fft256_pkg;

    localparam int N       = 256;
    localparam int LOGN    = 8;
    localparam int BF_LAT  = 4;
    localparam int RD_LAT  = 1;
    localparam int DRAIN_W = $clog2(BF_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        DRAIN,
        UNLOAD
    } state_t;

    function automatic logic [LOGN-1:0] bitrev8(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = x[LOGN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft256_ctrl_if.sv
// Address/strobe bundle between the FFT sequencer (master) and the datapath (slave).
interface fft256_ctrl_if;
    import fft256_pkg::*;

    logic            inv;
    logic            valid_in;
    logic            sop_in;
    logic            wr_en;
    logic [LOGN-1:0] wr_addr;
    logic            bf_en;
    logic [LOGN-1:0] bf_addr_a;
    logic [LOGN-1:0] bf_addr_b;
    logic [6:0]      tw_idx;
    logic [2:0]      stage;
    logic            wb_en;
    logic [LOGN-1:0] wb_addr_a;
    logic [LOGN-1:0] wb_addr_b;
    logic            inv_q;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr;
    logic            valid_out;
    logic            sop_out;
    logic            busy;
    logic            err;

    modport master (
        input  inv, valid_in, sop_in,
        output wr_en, wr_addr, bf_en, bf_addr_a, bf_addr_b, tw_idx, stage,
               wb_en, wb_addr_a, wb_addr_b, inv_q, rd_en, rd_addr,
               valid_out, sop_out, busy, err
    );

    modport slave (
        output inv, valid_in, sop_in,
        input  wr_en, wr_addr, bf_en, bf_addr_a, bf_addr_b, tw_idx, stage,
               wb_en, wb_addr_a, wb_addr_b, inv_q, rd_en, rd_addr,
               valid_out, sop_out, busy, err
    );

endinterface

// File: rtl/fft256_agu.sv
// Combinational radix-2 butterfly address and twiddle-index generator for
// stage s, butterfly k.
module fft256_agu
    import fft256_pkg::*;
(
    input  logic [2:0]      s,
    input  logic [6:0]      k,
    output logic [LOGN-1:0] a,
    output logic [LOGN-1:0] b,
    output logic [6:0]      tw_idx
);

    logic [LOGN-1:0] k_ext;
    logic [LOGN-1:0] pos;
    logic [LOGN-1:0] grp;

    always_comb begin
        k_ext  = {1'b0, k};
        pos    = k_ext & ((8'd1 << s) - 8'd1);
        grp    = k_ext >> s;
        a      = ((grp << 1) << s) | pos;
        b      = a | (8'd1 << s);
        // pos < 2^s, so the shifted index always fits in 7 bits
        tw_idx = pos[6:0] << (3'd7 - s);
    end

endmodule

// File: rtl/fft256_ctrl.sv
// Frame sequencer for the 256-point in-place FFT: bit-reversed load, 8 stages
// of 128 butterflies with a writeback drain per stage, natural-order unload.
module fft256_ctrl
    import fft256_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fft256_ctrl_if.master bus
);

    state_t               state_reg;
    logic [LOGN-1:0]      cnt_reg;
    logic [2:0]           s_reg;
    logic [6:0]           k_reg;
    logic [DRAIN_W-1:0]   dcnt_reg;
    logic                 wr_en_reg, bf_en_reg, rd_en_reg;
    logic                 inv_q_reg, busy_reg, err_reg;
    logic [LOGN-1:0]      wr_addr_reg, bf_a_reg, bf_b_reg, rd_addr_reg;
    logic [6:0]           tw_reg;
    logic [LOGN-1:0]      agu_a, agu_b;
    logic [6:0]           agu_tw;

    fft256_agu u_agu (
        .s      (s_reg),
        .k      (k_reg),
        .a      (agu_a),
        .b      (agu_b),
        .tw_idx (agu_tw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            s_reg       <= '0;
            k_reg       <= '0;
            dcnt_reg    <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            bf_en_reg   <= 1'b0;
            bf_a_reg    <= '0;
            bf_b_reg    <= '0;
            tw_reg      <= '0;
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
            inv_q_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            bf_en_reg <= 1'b0;
            rd_en_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.valid_in && bus.sop_in) begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= '0;
                        cnt_reg     <= 8'd1;
                        inv_q_reg   <= bus.inv;
                        busy_reg    <= 1'b1;
                        state_reg   <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.valid_in) begin
                        wr_en_reg <= 1'b1;
                        if (bus.sop_in) begin
                            err_reg     <= 1'b1;
                            wr_addr_reg <= '0;
                            cnt_reg     <= 8'd1;
                            inv_q_reg   <= bus.inv;
                        end else begin
                            wr_addr_reg <= bitrev8(cnt_reg);
                            // wraps to 0 after sample 255, ready to serve as the read counter
                            cnt_reg     <= cnt_reg + 8'd1;
                            if (cnt_reg == 8'd255) begin
                                s_reg     <= '0;
                                k_reg     <= '0;
                                state_reg <= CALC;
                            end
                        end
                    end
                end
                CALC: begin
                    err_reg   <= bus.valid_in;
                    bf_en_reg <= 1'b1;
                    bf_a_reg  <= agu_a;
                    bf_b_reg  <= agu_b;
                    tw_reg    <= agu_tw;
                    k_reg     <= k_reg + 7'd1;
                    if (k_reg == 7'd127) begin
                        dcnt_reg  <= '0;
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    err_reg <= bus.valid_in;
                    if (dcnt_reg == DRAIN_W'(BF_LAT - 1)) begin
                        if (s_reg == 3'd7) begin
                            state_reg <= UNLOAD;
                        end else begin
                            s_reg     <= s_reg + 3'd1;
                            state_reg <= CALC;
                        end
                    end else begin
                        dcnt_reg <= dcnt_reg + DRAIN_W'(1);
                    end
                end
                UNLOAD: begin
                    err_reg     <= bus.valid_in;
                    rd_en_reg   <= 1'b1;
                    rd_addr_reg <= cnt_reg;
                    cnt_reg     <= cnt_reg + 8'd1;
                    if (cnt_reg == 8'd255) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Writeback and output framing delay lines, one register stage per element.
    logic            wb_en_pipe [BF_LAT];
    logic [LOGN-1:0] wb_a_pipe  [BF_LAT];
    logic [LOGN-1:0] wb_b_pipe  [BF_LAT];
    logic            vo_pipe    [RD_LAT];
    logic            so_pipe    [RD_LAT];

    for (genvar gi = 0; gi < BF_LAT; gi++) begin : g_wb
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    wb_en_pipe[gi] <= 1'b0;
                    wb_a_pipe[gi]  <= '0;
                    wb_b_pipe[gi]  <= '0;
                end else begin
                    wb_en_pipe[gi] <= bf_en_reg;
                    wb_a_pipe[gi]  <= bf_a_reg;
                    wb_b_pipe[gi]  <= bf_b_reg;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst) begin
                    wb_en_pipe[gi] <= 1'b0;
                    wb_a_pipe[gi]  <= '0;
                    wb_b_pipe[gi]  <= '0;
                end else begin
                    wb_en_pipe[gi] <= wb_en_pipe[gi-1];
                    wb_a_pipe[gi]  <= wb_a_pipe[gi-1];
                    wb_b_pipe[gi]  <= wb_b_pipe[gi-1];
                end
            end
        end
    end

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rd
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    vo_pipe[gi] <= 1'b0;
                    so_pipe[gi] <= 1'b0;
                end else begin
                    vo_pipe[gi] <= rd_en_reg;
                    so_pipe[gi] <= rd_en_reg && (rd_addr_reg == '0);
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst) begin
                    vo_pipe[gi] <= 1'b0;
                    so_pipe[gi] <= 1'b0;
                end else begin
                    vo_pipe[gi] <= vo_pipe[gi-1];
                    so_pipe[gi] <= so_pipe[gi-1];
                end
            end
        end
    end

    assign bus.wr_en     = wr_en_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.bf_en     = bf_en_reg;
    assign bus.bf_addr_a = bf_a_reg;
    assign bus.bf_addr_b = bf_b_reg;
    assign bus.tw_idx    = tw_reg;
    assign bus.stage     = s_reg;
    assign bus.wb_en     = wb_en_pipe[BF_LAT-1];
    assign bus.wb_addr_a = wb_a_pipe[BF_LAT-1];
    assign bus.wb_addr_b = wb_b_pipe[BF_LAT-1];
    assign bus.inv_q     = inv_q_reg;
    assign bus.rd_en     = rd_en_reg;
    assign bus.rd_addr   = rd_addr_reg;
    assign bus.valid_out = vo_pipe[RD_LAT-1];
    assign bus.sop_out   = so_pipe[RD_LAT-1];
    assign bus.busy      = busy_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_fft256_ctrl.sv
// Directed bench for fft256_ctrl: frame timing, address sequences, error and
// reset behaviour, with a negedge monitor that logs every strobe.
module tb_fft256_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft256_ctrl_if bus ();

    fft256_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int wr_log   [512];
    int bf_a_log [1024];
    int bf_b_log [1024];
    int bf_t_log [1024];
    int bf_s_log [1024];
    int bf_c_log [1024];
    int wr_cnt, bf_cnt, wb_cnt, wb_errs, rd_cnt, rd_errs, vo_cnt, sop_cnt, err_cnt;
    int last_wr_cyc, first_bf_cyc, sop_cyc, last_vo_cyc;
    logic inv_at_sop;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (wr_cnt < 512) wr_log[wr_cnt] = int'(bus.wr_addr);
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (bus.bf_en) begin
            if (bf_cnt == 0) first_bf_cyc = cyc;
            if (bf_cnt < 1024) begin
                bf_a_log[bf_cnt] = int'(bus.bf_addr_a);
                bf_b_log[bf_cnt] = int'(bus.bf_addr_b);
                bf_t_log[bf_cnt] = int'(bus.tw_idx);
                bf_s_log[bf_cnt] = int'(bus.stage);
                bf_c_log[bf_cnt] = cyc;
            end
            bf_cnt++;
        end
        if (bus.wb_en) begin
            if (wb_cnt >= 1024 || int'(bus.wb_addr_a) != bf_a_log[wb_cnt] ||
                int'(bus.wb_addr_b) != bf_b_log[wb_cnt] || cyc - bf_c_log[wb_cnt] != 4)
                wb_errs++;
            wb_cnt++;
        end
        if (bus.rd_en) begin
            if (int'(bus.rd_addr) != rd_cnt) rd_errs++;
            rd_cnt++;
        end
        if (bus.valid_out) begin
            vo_cnt++;
            last_vo_cyc = cyc;
        end
        if (bus.sop_out) begin
            if (!bus.valid_out) rd_errs++;
            sop_cnt++;
            sop_cyc    = cyc;
            inv_at_sop = bus.inv_q;
        end
        if (bus.err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rev8(input int x);
        int r = 0;
        for (int i = 0; i < 8; i++) if (x[i]) r |= 1 << (7 - i);
        return r;
    endfunction

    task automatic clear_log();
        wr_cnt = 0; bf_cnt = 0; wb_cnt = 0; wb_errs = 0; rd_cnt = 0; rd_errs = 0;
        vo_cnt = 0; sop_cnt = 0; err_cnt = 0;
        last_wr_cyc = -1; first_bf_cyc = -1; sop_cyc = -1; last_vo_cyc = -1;
        inv_at_sop = 1'bx;
    endtask

    // Called at posedge+1; each sample is taken at the following posedge.
    task automatic send(input int n, input int gap, input bit inv_v);
        for (int i = 0; i < n; i++) begin
            bus.valid_in = 1'b1;
            bus.sop_in   = (i == 0);
            bus.inv      = (i == 0) ? inv_v : ~inv_v;
            @(posedge clk); #1;
            bus.valid_in = 1'b0;
            bus.sop_in   = 1'b0;
            bus.inv      = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic pulse_valid(input int n, input bit sop);
        bus.valid_in = 1'b1;
        bus.sop_in   = sop;
        repeat (n) @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.sop_in   = 1'b0;
    endtask

    task automatic wait_done(input string t);
        int n = 0;
        @(negedge clk);
        while (!(vo_cnt >= 256 && !bus.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check({t, "_done_timeout"}, 32'(n), 32'd0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input string t, input int base, input bit exp_inv, input int exp_err);
        int errs = 0;
        for (int i = 0; i < 256; i++) if (wr_log[base + i] != rev8(i)) errs++;
        check({t, "_wr_seq"},      32'(errs), 32'd0);
        check({t, "_wr_cnt"},      32'(wr_cnt - base), 32'd256);
        check({t, "_first_bf"},    32'(first_bf_cyc - last_wr_cyc), 32'd1);
        check({t, "_bf_cnt"},      32'(bf_cnt), 32'd1024);
        check({t, "_wb"},          32'(wb_errs), 32'd0);
        check({t, "_wb_cnt"},      32'(wb_cnt), 32'd1024);
        check({t, "_sop_lat"},     32'(sop_cyc - last_wr_cyc), 32'd1058);
        check({t, "_last_vo_lat"}, 32'(last_vo_cyc - last_wr_cyc), 32'd1313);
        check({t, "_vo_cnt"},      32'(vo_cnt), 32'd256);
        check({t, "_sop_cnt"},     32'(sop_cnt), 32'd1);
        check({t, "_rd_seq"},      32'(rd_errs), 32'd0);
        check({t, "_rd_cnt"},      32'(rd_cnt), 32'd256);
        check({t, "_inv_q"},       32'(inv_at_sop), 32'(exp_inv));
        check({t, "_err_cnt"},     32'(err_cnt), 32'(exp_err));
        check({t, "_busy_end"},    32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        int serr;
        bus.valid_in = 1'b0;
        bus.sop_in   = 1'b0;
        bus.inv      = 1'b0;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", 32'({bus.wr_en, bus.bf_en, bus.wb_en, bus.rd_en,
                                    bus.valid_out, bus.sop_out, bus.busy, bus.err}), 32'd0);
        check("reset_addrs", 32'({bus.wr_addr, bus.bf_addr_a, bus.rd_addr, bus.stage}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // contiguous frame, inverse requested
        clear_log();
        send(256, 0, 1'b1);
        wait_done("contig");
        check_frame("contig", 0, 1'b1, 0);
        check("wr_addr_1", 32'(wr_log[1]), 32'd128);
        check("wr_addr_3", 32'(wr_log[3]), 32'd192);
        check("s0k0_ab", 32'({bf_a_log[0][7:0], bf_b_log[0][7:0], bf_t_log[0][7:0]}), {8'd0, 8'd0, 8'd1, 8'd0});
        check("s0k1_ab", 32'({bf_a_log[1][7:0], bf_b_log[1][7:0], bf_t_log[1][7:0]}), {8'd0, 8'd2, 8'd3, 8'd0});
        check("s3k9_a",  32'(bf_a_log[3*128+9]), 32'd17);
        check("s3k9_b",  32'(bf_b_log[3*128+9]), 32'd25);
        check("s3k9_tw", 32'(bf_t_log[3*128+9]), 32'd16);
        check("s7k127_a",  32'(bf_a_log[1023]), 32'd127);
        check("s7k127_b",  32'(bf_b_log[1023]), 32'd255);
        check("s7k127_tw", 32'(bf_t_log[1023]), 32'd127);
        serr = 0;
        for (int i = 0; i < 1024; i++) if (bf_s_log[i] != i / 128) serr++;
        check("stage_seq", 32'(serr), 32'd0);

        // gapped input, one valid every third cycle
        clear_log();
        send(256, 2, 1'b0);
        wait_done("gap");
        check_frame("gap", 0, 1'b0, 0);

        // restart by a second sop at sample 100
        clear_log();
        send(100, 0, 1'b0);
        send(256, 0, 1'b1);
        wait_done("midsop");
        check_frame("midsop", 100, 1'b1, 1);
        check("midsop_wr99", 32'(wr_log[99]), 32'(rev8(99)));
        check("midsop_wr100", 32'(wr_log[100]), 32'd0);

        // input during CALC (3 cycles) and UNLOAD (2 cycles, with sop)
        clear_log();
        send(256, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        pulse_valid(3, 1'b0);
        n = 0;
        while (cyc < last_wr_cyc + 1100 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        pulse_valid(2, 1'b1);
        wait_done("drop");
        check_frame("drop", 0, 1'b0, 5);

        // reset at stage 4, k = 50 (a = 98)
        clear_log();
        send(256, 0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!(bus.bf_en && bus.stage == 3'd4 && bus.bf_addr_a == 8'd98) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_s4k50", 32'(bus.bf_addr_b), 32'd114);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_strobes", 32'({bus.wr_en, bus.bf_en, bus.wb_en, bus.rd_en,
                                  bus.valid_out, bus.sop_out, bus.busy, bus.err}), 32'd0);
        check("rst_err_none", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_log();
        send(256, 0, 1'b1);
        wait_done("post_rst");
        check_frame("post_rst", 0, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
